// File: rtl/tx_request_arbiter.sv
// Purpose: round-robin share of one serial transmitter between two byte requesters.
// Latency: req -> grant/tx_send/tx_data 1 cycle; tx_busy seen -> ack 1 cycle.
// Backpressure: tx_send held until tx_busy; no new launch while tx_busy=1.
// Optional launch timeout: define TX_ARB_TIMEOUT_EN.
module tx_request_arbiter #(
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic [1:0]        ack,
  output logic [1:0]        grant,
  output logic              tx_send,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              tx_err
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if (2**TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("tx_request_arbiter: TIMEOUT_W too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        ack_nxt, grant_nxt;
  logic              tx_send_nxt;
  logic [DATA_W-1:0] tx_data_nxt;
  logic              last, last_nxt;   // index of the most recent winner
  logic              win;              // index of the requester that wins in IDLE

`ifdef TX_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt, cnt_nxt;
  logic                 tx_err_nxt;
`endif

  // Pick the sole requester, or the one that did not win last time on a tie.
  always_comb begin
    win = req[1];
    if (req == 2'b11) win = ~last;
  end

  // Next-state and next-output logic; every register defaults to hold, pulses default to 0.
  always_comb begin
    state_nxt   = state;
    ack_nxt     = 2'b00;
    grant_nxt   = grant;
    tx_send_nxt = tx_send;
    tx_data_nxt = tx_data;
    last_nxt    = last;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
    tx_err_nxt  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // A busy transmitter here is a frame we do not own (e.g. left over across reset).
        if (!tx_busy && (req != 2'b00)) begin
          grant_nxt   = win ? 2'b10 : 2'b01;
          tx_data_nxt = win ? data1 : data0;
          tx_send_nxt = 1'b1;
          state_nxt   = S_LAUNCH;
`ifdef TX_ARB_TIMEOUT_EN
          cnt_nxt     = '0;
`endif
        end
      end
      S_LAUNCH: begin
        tx_send_nxt = 1'b1;
        if (tx_busy) begin
          tx_send_nxt = 1'b0;
          ack_nxt     = grant;
          last_nxt    = grant[1];
          state_nxt   = S_WAIT_DONE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          // Transmitter never accepted: abandon the byte without ack, rotate priority.
          tx_send_nxt = 1'b0;
          grant_nxt   = 2'b00;
          tx_err_nxt  = 1'b1;
          last_nxt    = grant[1];
          state_nxt   = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      S_WAIT_DONE: begin
        tx_send_nxt = 1'b0;
        if (!tx_busy) begin
          grant_nxt = 2'b00;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        tx_send_nxt = 1'b0;
        grant_nxt   = 2'b00;
        state_nxt   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; last=1 makes requester 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      ack     <= 2'b00;
      grant   <= 2'b00;
      tx_send <= 1'b0;
      tx_data <= '0;
      last    <= 1'b1;
    end else begin
      state   <= state_nxt;
      ack     <= ack_nxt;
      grant   <= grant_nxt;
      tx_send <= tx_send_nxt;
      tx_data <= tx_data_nxt;
      last    <= last_nxt;
    end
  end

`ifdef TX_ARB_TIMEOUT_EN
  // Launch timeout counter and registered error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      tx_err <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tx_err <= tx_err_nxt;
    end
  end
`else
  assign tx_err = 1'b0;
`endif

endmodule
